// File: rtl/rf_dual_port.sv
// Register file with one accumulator-fed write port and two registered read ports.
// Adds write-to-read forwarding, an optional debug-mapped index and a post-reset clear.
//
// state | meaning
// CLEAR | zeroing registers[clr_cnt] one per cycle; requests ignored, busy high
// RUN   | normal read/write service until the next rst
module rf_dual_port #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 4,
    parameter int ADDR_WIDTH = 2,
    parameter bit DBG_EN     = 1'b1,
    parameter int DBG_IDX    = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  ld_ce,
    input  logic [ADDR_WIDTH-1:0] ld_addr,
    input  logic                  ld_ce_b,
    input  logic [ADDR_WIDTH-1:0] ld_addr_b,
    input  logic                  st_ce,
    input  logic [ADDR_WIDTH-1:0] st_addr,
    input  logic [DATA_WIDTH-1:0] acc,
    input  logic [DATA_WIDTH-1:0] debug_reg,
    output logic [DATA_WIDTH-1:0] data,
    output logic [DATA_WIDTH-1:0] data_b,
    output logic                  busy
);

    localparam logic [ADDR_WIDTH:0]   DEPTH_W  = (ADDR_WIDTH+1)'(DEPTH);
    localparam logic [ADDR_WIDTH-1:0] LAST_IDX = ADDR_WIDTH'(DEPTH - 1);
    localparam logic [ADDR_WIDTH-1:0] DBG_ADDR = ADDR_WIDTH'(DBG_IDX);

    typedef enum logic {CLEAR, RUN} state_t;

    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] clr_cnt_q, clr_cnt_d;
    logic                  busy_q, busy_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic [DATA_WIDTH-1:0] data_b_q, data_b_d;
    logic [DATA_WIDTH-1:0] mem_q [DEPTH];

    logic                  wr_en;
    logic [ADDR_WIDTH-1:0] wr_idx;
    logic [DATA_WIDTH-1:0] wr_data;

    function automatic logic in_range(input logic [ADDR_WIDTH-1:0] a);
        return {1'b0, a} < DEPTH_W;
    endfunction

    // Debug mapping outranks the range check and forwarding.
    function automatic logic [DATA_WIDTH-1:0] read_next(
        input logic                  ce,
        input logic [ADDR_WIDTH-1:0] addr,
        input logic [DATA_WIDTH-1:0] cur,
        input logic [DATA_WIDTH-1:0] stored
    );
        if (!ce)
            return cur;
        if (DBG_EN && addr == DBG_ADDR)
            return debug_reg;
        if (!in_range(addr))
            return '0;
        if (st_ce && st_addr == addr)
            return acc;
        return stored;
    endfunction

    always_comb begin
        state_d   = state_q;
        clr_cnt_d = clr_cnt_q;
        busy_d    = busy_q;
        data_d    = data_q;
        data_b_d  = data_b_q;
        wr_en     = 1'b0;
        wr_idx    = st_addr;
        wr_data   = acc;
        if (state_q == CLEAR) begin
            wr_en     = 1'b1;
            wr_idx    = clr_cnt_q;
            wr_data   = '0;
            clr_cnt_d = clr_cnt_q + ADDR_WIDTH'(1);
            if (clr_cnt_q == LAST_IDX) begin
                state_d = RUN;
                busy_d  = 1'b0;
            end
        end else begin
            busy_d   = 1'b0;
            wr_en    = st_ce && in_range(st_addr);
            data_d   = read_next(ld_ce, ld_addr, data_q, mem_q[ld_addr]);
            data_b_d = read_next(ld_ce_b, ld_addr_b, data_b_q, mem_q[ld_addr_b]);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= CLEAR;
            clr_cnt_q <= '0;
            busy_q    <= 1'b1;
            data_q    <= '0;
            data_b_q  <= '0;
        end else begin
            state_q   <= state_d;
            clr_cnt_q <= clr_cnt_d;
            busy_q    <= busy_d;
            data_q    <= data_d;
            data_b_q  <= data_b_d;
        end
    end

    // Storage has no reset; the CLEAR sequence zeroes it instead.
    always_ff @(posedge clk) begin
        if (wr_en)
            mem_q[wr_idx] <= wr_data;
    end

    assign data   = data_q;
    assign data_b = data_b_q;
    assign busy   = busy_q;

endmodule

// File: tb/tb_rf_dual_port.sv
// Bench for rf_dual_port: three instances (DEPTH 4 with debug, DEPTH 4 without, DEPTH 3)
// share stimulus; a behavioural model and a hand-written vector table feed a scoreboard.
module tb_rf_dual_port;

    logic       clk;
    logic       rst;
    logic       ld_ce, ld_ce_b, st_ce;
    logic [1:0] ld_addr, ld_addr_b, st_addr;
    logic [7:0] acc, debug_reg;
    logic [7:0] data0, data_b0, data1, data_b1, data2, data_b2;
    logic       busy0, busy1, busy2;

    rf_dual_port #(.DATA_WIDTH(8), .DEPTH(4), .ADDR_WIDTH(2), .DBG_EN(1'b1), .DBG_IDX(3)) u_dut0 (
        .clk(clk), .rst(rst), .ld_ce(ld_ce), .ld_addr(ld_addr), .ld_ce_b(ld_ce_b),
        .ld_addr_b(ld_addr_b), .st_ce(st_ce), .st_addr(st_addr), .acc(acc),
        .debug_reg(debug_reg), .data(data0), .data_b(data_b0), .busy(busy0));

    rf_dual_port #(.DATA_WIDTH(8), .DEPTH(4), .ADDR_WIDTH(2), .DBG_EN(1'b0), .DBG_IDX(3)) u_dut1 (
        .clk(clk), .rst(rst), .ld_ce(ld_ce), .ld_addr(ld_addr), .ld_ce_b(ld_ce_b),
        .ld_addr_b(ld_addr_b), .st_ce(st_ce), .st_addr(st_addr), .acc(acc),
        .debug_reg(debug_reg), .data(data1), .data_b(data_b1), .busy(busy1));

    rf_dual_port #(.DATA_WIDTH(8), .DEPTH(3), .ADDR_WIDTH(2), .DBG_EN(1'b0), .DBG_IDX(2)) u_dut2 (
        .clk(clk), .rst(rst), .ld_ce(ld_ce), .ld_addr(ld_addr), .ld_ce_b(ld_ce_b),
        .ld_addr_b(ld_addr_b), .st_ce(st_ce), .st_addr(st_addr), .acc(acc),
        .debug_reg(debug_reg), .data(data2), .data_b(data_b2), .busy(busy2));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int         k;
        logic [7:0] a;
        logic [7:0] b;
        logic       busy;
        string      tag;
    } exp_t;

    typedef struct {
        bit         lce;
        logic [1:0] la;
        bit         lceb;
        logic [1:0] lb;
        bit         sce;
        logic [1:0] sa;
        logic [7:0] acc;
        logic [7:0] dbg;
        logic [7:0] ea;
        logic [7:0] eb;
    } vec_t;

    exp_t sb[$];
    vec_t vecs[13];

    int total  = 0;
    int passed = 0;

    int dep[3] = '{4, 4, 3};
    bit dbe[3] = '{1'b1, 1'b0, 1'b0};
    int dbi[3] = '{3, 3, 2};
    logic [7:0] mm[3][4];
    logic [7:0] ea[3], eb[3];
    bit         run_m[3];
    int         clr_m[3];

    task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h", nm, act, exp);
    endtask

    function automatic logic [7:0] model_rd(input int k, input bit ce, input logic [1:0] a,
                                            input logic [7:0] cur);
        if (!ce) return cur;
        if (dbe[k] && int'(a) == dbi[k]) return debug_reg;
        if (int'(a) >= dep[k]) return 8'h00;
        return mm[k][a];
    endfunction

    // Model applies the write first, so a same-cycle read naturally sees the new value.
    task automatic model_edge();
        for (int k = 0; k < 3; k++) begin
            if (!run_m[k]) begin
                mm[k][clr_m[k]] = 8'h00;
                if (clr_m[k] == dep[k] - 1) begin
                    run_m[k] = 1'b1;
                    clr_m[k] = 0;
                end else begin
                    clr_m[k]++;
                end
            end else begin
                if (st_ce && int'(st_addr) < dep[k]) mm[k][st_addr] = acc;
                ea[k] = model_rd(k, ld_ce, ld_addr, ea[k]);
                eb[k] = model_rd(k, ld_ce_b, ld_addr_b, eb[k]);
            end
            sb.push_back('{k, ea[k], eb[k], !run_m[k], "model"});
        end
    endtask

    task automatic check_all();
        exp_t       e;
        logic [7:0] a, b;
        logic       bz;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            case (e.k)
                0:       begin a = data0; b = data_b0; bz = busy0; end
                1:       begin a = data1; b = data_b1; bz = busy1; end
                default: begin a = data2; b = data_b2; bz = busy2; end
            endcase
            chk($sformatf("%s_dut%0d_data", e.tag, e.k), a, e.a);
            chk($sformatf("%s_dut%0d_data_b", e.tag, e.k), b, e.b);
            chk($sformatf("%s_dut%0d_busy", e.tag, e.k), {7'b0, bz}, {7'b0, e.busy});
        end
    endtask

    task automatic cyc(input bit lce, input logic [1:0] la, input bit lceb, input logic [1:0] lb,
                       input bit sce, input logic [1:0] sa, input logic [7:0] d,
                       input logic [7:0] dbg);
        ld_ce = lce; ld_addr = la; ld_ce_b = lceb; ld_addr_b = lb;
        st_ce = sce; st_addr = sa; acc = d; debug_reg = dbg;
        model_edge();
        @(posedge clk);
        #1;
        check_all();
    endtask

    // Asynchronous reset between edges; outputs must react before any clock edge.
    task automatic do_reset();
        rst = 1'b1;
        #1;
        for (int k = 0; k < 3; k++) begin
            ea[k] = 8'h00; eb[k] = 8'h00; run_m[k] = 1'b0; clr_m[k] = 0;
            sb.push_back('{k, 8'h00, 8'h00, 1'b1, "reset"});
        end
        check_all();
        #1;
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        ld_ce = 1'b0; ld_ce_b = 1'b0; st_ce = 1'b0;
        ld_addr = 2'd0; ld_addr_b = 2'd0; st_addr = 2'd0;
        acc = 8'h00; debug_reg = 8'h7E;

        //          lce la    lceb lb    sce sa    acc    dbg    ea     eb
        vecs[0]  = '{1'b0, 2'd0, 1'b0, 2'd0, 1'b1, 2'd0, 8'h11, 8'h7E, 8'h00, 8'h00};
        vecs[1]  = '{1'b0, 2'd0, 1'b0, 2'd0, 1'b1, 2'd1, 8'h22, 8'h7E, 8'h00, 8'h00};
        vecs[2]  = '{1'b1, 2'd0, 1'b1, 2'd1, 1'b0, 2'd0, 8'h00, 8'h7E, 8'h11, 8'h22};
        vecs[3]  = '{1'b1, 2'd2, 1'b0, 2'd0, 1'b1, 2'd2, 8'h5C, 8'h7E, 8'h5C, 8'h22};
        vecs[4]  = '{1'b1, 2'd2, 1'b1, 2'd2, 1'b0, 2'd0, 8'h00, 8'h7E, 8'h5C, 8'h5C};
        vecs[5]  = '{1'b1, 2'd3, 1'b0, 2'd0, 1'b1, 2'd3, 8'h01, 8'h7E, 8'h7E, 8'h5C};
        vecs[6]  = '{1'b1, 2'd3, 1'b1, 2'd3, 1'b0, 2'd0, 8'h00, 8'h3C, 8'h3C, 8'h3C};
        vecs[7]  = '{1'b1, 2'd3, 1'b0, 2'd0, 1'b1, 2'd3, 8'h99, 8'h7E, 8'h7E, 8'h3C};
        vecs[8]  = '{1'b0, 2'd0, 1'b1, 2'd0, 1'b1, 2'd0, 8'hA5, 8'h7E, 8'h7E, 8'hA5};
        vecs[9]  = '{1'b0, 2'd1, 1'b0, 2'd1, 1'b1, 2'd1, 8'h77, 8'h7E, 8'h7E, 8'hA5};
        vecs[10] = '{1'b1, 2'd1, 1'b1, 2'd0, 1'b0, 2'd0, 8'h00, 8'h7E, 8'h77, 8'hA5};
        vecs[11] = '{1'b1, 2'd1, 1'b1, 2'd1, 1'b1, 2'd1, 8'h66, 8'h7E, 8'h66, 8'h66};
        vecs[12] = '{1'b1, 2'd2, 1'b1, 2'd0, 1'b0, 2'd0, 8'h00, 8'h7E, 8'h5C, 8'hA5};

        // Reset and clear, with a write and reads attempted while busy.
        do_reset();
        for (int i = 0; i < 4; i++) cyc(1'b1, 2'd0, 1'b1, 2'd1, 1'b1, 2'd0, 8'hAA, 8'h7E);
        sb.push_back('{0, 8'h00, 8'h00, 1'b0, "clr_r0"});
        cyc(1'b1, 2'd0, 1'b1, 2'd0, 1'b0, 2'd0, 8'h00, 8'h7E);

        for (int i = 0; i < 13; i++) begin
            sb.push_back('{0, vecs[i].ea, vecs[i].eb, 1'b0, $sformatf("vec%0d", i)});
            cyc(vecs[i].lce, vecs[i].la, vecs[i].lceb, vecs[i].lb,
                vecs[i].sce, vecs[i].sa, vecs[i].acc, vecs[i].dbg);
        end

        // Hold while r0 is rewritten, then out-of-range read and write on the DEPTH=3 instance.
        cyc(1'b1, 2'd0, 1'b0, 2'd0, 1'b1, 2'd0, 8'h11, 8'h7E);
        for (int i = 0; i < 3; i++) begin
            cyc(1'b0, 2'd0, 1'b0, 2'd0, 1'b1, 2'd0, 8'h40 + 8'(i), 8'h7E);
            chk("hold_dut2", data2, 8'h11);
        end
        cyc(1'b1, 2'd3, 1'b0, 2'd0, 1'b0, 2'd0, 8'h00, 8'h7E);
        chk("oor_read_dut2", data2, 8'h00);
        cyc(1'b0, 2'd0, 1'b0, 2'd0, 1'b1, 2'd3, 8'hFF, 8'h7E);
        cyc(1'b1, 2'd0, 1'b1, 2'd1, 1'b0, 2'd0, 8'h00, 8'h7E);
        chk("oor_write_r0_dut2", data2, 8'h42);
        chk("oor_write_r1_dut2", data_b2, 8'h66);
        cyc(1'b1, 2'd2, 1'b0, 2'd0, 1'b0, 2'd0, 8'h00, 8'h7E);
        chk("oor_write_r2_dut2", data2, 8'h5C);

        // Reset mid-run, then again after two clear edges; clear must restart from index 0.
        do_reset();
        for (int i = 0; i < 2; i++) cyc(1'b1, 2'd1, 1'b1, 2'd2, 1'b1, 2'd1, 8'hEE, 8'h7E);
        do_reset();
        for (int e = 1; e <= 4; e++) begin
            cyc(1'b0, 2'd0, 1'b0, 2'd0, 1'b0, 2'd0, 8'h00, 8'h7E);
            chk($sformatf("busy_edge%0d_dut0", e), {7'b0, busy0}, (e < 4) ? 8'h01 : 8'h00);
            chk($sformatf("busy_edge%0d_dut2", e), {7'b0, busy2}, (e < 3) ? 8'h01 : 8'h00);
        end
        cyc(1'b1, 2'd0, 1'b1, 2'd1, 1'b0, 2'd0, 8'h00, 8'h7E);
        chk("reclear_r0_dut0", data0, 8'h00);
        chk("reclear_r1_dut0", data_b0, 8'h00);
        cyc(1'b1, 2'd2, 1'b1, 2'd3, 1'b0, 2'd0, 8'h00, 8'h7E);
        chk("reclear_r2_dut1", data1, 8'h00);
        chk("reclear_r3_dut1", data_b1, 8'h00);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/rf_dual_port.md
# rf_dual_port

Parametrised successor to the accumulator machine's register file. It provides one write port fed from the accumulator and two independent registered read ports, so two operands can be fetched per cycle. It adds same-cycle write-to-read forwarding, a configurable debug-mapped register, and a post-reset hardware clear sequence. It sits between the decoder (addresses and enables) and the ALU/accumulator datapath.

## Interface
- DATA_WIDTH, 8, width of each register and of all data ports
- DEPTH, 4, number of registers; any value ≥ 2, not required to be a power of two
- ADDR_WIDTH, 2, address width; must satisfy 2^ADDR_WIDTH ≥ DEPTH
- DBG_EN, 1, 1 maps register DBG_IDX reads to debug_reg; 0 disables the mapping
- DBG_IDX, 3, index of the debug-mapped register; must be < DEPTH
- clk  in  1  clock; all state changes on rising edge
- rst  in  1  asynchronous, active-high reset
- ld_ce  in  1  read enable, port A
- ld_addr  in  ADDR_WIDTH  read address, port A
- ld_ce_b  in  1  read enable, port B
- ld_addr_b  in  ADDR_WIDTH  read address, port B
- st_ce  in  1  write enable
- st_addr  in  ADDR_WIDTH  write address
- acc  in  DATA_WIDTH  write data from the accumulator
- debug_reg  in  DATA_WIDTH  external value returned for reads of DBG_IDX
- data  out  DATA_WIDTH  registered read data, port A
- data_b  out  DATA_WIDTH  registered read data, port B
- busy  out  1  high while the clear sequence runs; all requests are ignored while high

## Operation
- Two states: CLEAR and RUN, plus a clear counter clr_cnt of ADDR_WIDTH bits.
- Reset (asynchronous, takes effect immediately) drives state to CLEAR, clr_cnt to 0, data to 0, data_b to 0, and busy to 1. Storage contents are not reset directly.
- CLEAR state:
  - Each cycle writes 0 to registers[clr_cnt] and increments clr_cnt.
  - When clr_cnt = DEPTH-1, that write completes, then the state moves to RUN on the same edge.
  - ld_ce, ld_ce_b, and st_ce are ignored. data and data_b hold 0.
- RUN state:
  - busy = 0. The state stays in RUN until the next rst.
- Write: if st_ce and st_addr < DEPTH, registers[st_addr] <= acc. Writes with st_addr ≥ DEPTH are dropped.
- Read, applied to each port independently (port A shown; port B uses ld_ce_b, ld_addr_b, data_b). The rules are evaluated in priority order:
  1. ld_ce = 0: data holds its previous value.
  2. DBG_EN = 1 and ld_addr = DBG_IDX: data <= debug_reg. This takes priority over forwarding.
  3. ld_addr ≥ DEPTH: data <= 0.
  4. st_ce = 1 and st_addr = ld_addr: data <= acc (forwarding).
  5. Otherwise: data <= registers[ld_addr].
- A write to DBG_IDX still updates storage. The stored value is observable only when DBG_EN = 0.
- Both ports may read the same address in the same cycle. They return identical values.

## Timing
- Read latency: 1 cycle. Address and enable are sampled on edge N; data is valid after edge N and remains stable until the next enabled read on that port.
- Write latency: 1 cycle. Data is stored on edge N.
  - A read issued at N+1 sees the new value.
  - A read issued at edge N sees it through forwarding.
- After rst deasserts, busy stays high for exactly DEPTH rising edges. The first request is accepted on edge DEPTH+1.
- If rst is asserted mid-CLEAR or mid-RUN, the block returns immediately to the reset values. The full clear sequence restarts from index 0 after release.
- No combinational path exists from any input to data, data_b, or busy. All outputs are registered.

## Test plan
- Reset/clear (DEPTH=4): rst pulse, then idle → busy=1 for 4 edges, then 0. During busy, st_ce=1, st_addr=0, acc=0xAA → dropped; after clear, a read of r0 returns 0x00.
- Write then read (DBG_EN=1, DBG_IDX=3): write 0x11 to r0 and 0x22 to r1, then ld_addr=0, ld_addr_b=1 in the same cycle → data=0x11 and data_b=0x22 one cycle later.
- Forwarding: st_ce=1, st_addr=2, acc=0x5C with ld_ce=1, ld_addr=2 in the same cycle → data=0x5C after that edge; a read of r2 on the next cycle also returns 0x5C.
- Debug mapping: debug_reg=0x7E, write acc=0x01 to r3, read r3 → 0x7E. The same sequence with DBG_EN=0 → 0x01.
- Hold and out-of-range (DEPTH=3, ADDR_WIDTH=2): data=0x11, then ld_ce=0 for 3 cycles while r0 is rewritten → data stays 0x11. A read of addr 3 → 0x00. A write to addr 3 leaves r0–r2 unchanged.
- Reset mid-clear: assert rst at edge 2 of CLEAR → busy stays 1; after release, busy falls exactly DEPTH edges later.
